// File: rtl/buf_fifo.sv
// buf_fifo: WIDTH x DEPTH first-word fall-through FIFO with valid/ready handshakes on both sides.
// Define BUF_BYPASS_EN to add a zero-latency pass-through path while the buffer is empty.
module buf_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [WIDTH-1:0] bufin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] bufout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;
   logic             bypass;
   logic             wr_en;
   logic             rd_en;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

`ifdef BUF_BYPASS_EN
   assign bypass    = empty && in_valid && !clr;
   assign out_valid = !empty || bypass;
   assign bufout    = empty ? bufin : mem[rd_ptr];
`else
   assign bypass    = 1'b0;
   assign out_valid = !empty;
   assign bufout    = mem[rd_ptr];
`endif

   // A word taken straight through the bypass is never stored.
   assign wr_en = push && !(bypass && out_ready);
   assign rd_en = pop && !empty;

   always_ff @(posedge clk) begin
      if (wr_en && !clr) begin
         mem[wr_ptr] <= bufin;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_buf_fifo.sv
// Directed self-checking bench for buf_fifo: a 16x4 instance for directed scenarios and a
// 32x8 instance for randomised backpressure against a queue scoreboard.
module tb_buf_fifo;

`ifdef BUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic [15:0] bufin;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] bufout;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   logic        clr8;
   logic [31:0] bufin8;
   logic        in_valid8;
   logic        in_ready8;
   logic [31:0] bufout8;
   logic        out_valid8;
   logic        out_ready8;
   logic [3:0]  count8;
   logic        full8;
   logic        empty8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   buf_fifo #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bufin(bufin), .in_valid(in_valid),
      .in_ready(in_ready), .bufout(bufout), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .full(full), .empty(empty)
   );

   buf_fifo #(.WIDTH(32), .DEPTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .clr(clr8), .bufin(bufin8), .in_valid(in_valid8),
      .in_ready(in_ready8), .bufout(bufout8), .out_valid(out_valid8), .out_ready(out_ready8),
      .count(count8), .full(full8), .empty(empty8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] d [3];
      d[0] = 16'h0101; d[1] = 16'h0202; d[2] = 16'h0303;
      rst_n = 1'b0;
      #2;
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1
          || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: count=%0d empty=%b full=%b in_ready=%b out_valid=%b, want 0 1 0 1 0",
                  count, empty, full, in_ready, out_valid);
      end
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         bufin    = d[i];
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL reset_prefill: count=%0d want 3", count);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: count=%0d empty=%b in_ready=%b out_valid=%b, want 0 1 1 0",
                  count, empty, in_ready, out_valid);
      end
      #2 rst_n = 1'b1;
      in_valid = 1'b1;
      bufin    = 16'h0BEE;
      tick();
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd1 || out_valid !== 1'b1 || bufout !== 16'h0BEE) begin
         errors++;
         $display("FAIL reset_first_push: count=%0d out_valid=%b bufout=%h, want 1 1 0bee",
                  count, out_valid, bufout);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_pop: empty=%b want 1", empty);
      end
   endtask

   task automatic test_fill_drain();
      logic [15:0] d [4];
      d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         bufin    = d[i];
         tick();
      end
      checks++;
      if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
         errors++;
         $display("FAIL fill_full: full=%b in_ready=%b count=%0d, want 1 0 4", full, in_ready, count);
      end
      bufin = 16'hDEAD;
      tick();
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd4 || bufout !== 16'h1111) begin
         errors++;
         $display("FAIL fill_refuse: count=%0d head=%h, want 4 1111", count, bufout);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || bufout !== d[i]) begin
            errors++;
            $display("FAIL drain_%0d: out_valid=%b bufout=%h, want 1 %h", i, out_valid, bufout, d[i]);
         end
         tick();
      end
      out_ready = 1'b0;
      checks++;
      if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL drain_empty: empty=%b out_valid=%b count=%0d, want 1 0 0",
                  empty, out_valid, count);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] q [$];
      logic [15:0] w;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         w = 16'hC000 + 16'(i);
         in_valid = 1'b1;
         bufin    = w;
         q.push_back(w);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         w     = 16'($urandom);
         bufin = w;
         #1;
         checks++;
         if (out_valid !== 1'b1 || bufout !== q[0]) begin
            errors++;
            $display("FAIL b2b_data_%0d: out_valid=%b bufout=%h, want 1 %h", i, out_valid, bufout, q[0]);
         end
         void'(q.pop_front());
         q.push_back(w);
         tick();
         checks++;
         if (count !== 3'd2) begin
            errors++;
            $display("FAIL b2b_count_%0d: count=%0d want 2", i, count);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (out_valid !== 1'b1 || bufout !== q[0]) begin
            errors++;
            $display("FAIL b2b_tail_%0d: out_valid=%b bufout=%h, want 1 %h", i, out_valid, bufout, q[0]);
         end
         void'(q.pop_front());
         tick();
      end
      out_ready = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL b2b_empty: empty=%b want 1", empty);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         bufin    = 16'hF000 + 16'(i);
         tick();
      end
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL flush_prefill: count=%0d want 3", count);
      end
      clr   = 1'b1;
      bufin = 16'hBAD0;
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_clear: count=%0d empty=%b out_valid=%b, want 0 1 0", count, empty, out_valid);
      end
      in_valid = 1'b1;
      bufin    = 16'h7777;
      tick();
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd1 || bufout !== 16'h7777) begin
         errors++;
         $display("FAIL flush_after: count=%0d bufout=%h, want 1 7777", count, bufout);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_bypass();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      bufin     = 16'hA5A5;
      #1;
`ifdef BUF_BYPASS_EN
      checks++;
      if (out_valid !== 1'b1 || bufout !== 16'hA5A5) begin
         errors++;
         $display("FAIL bypass_same_cycle: out_valid=%b bufout=%h, want 1 a5a5", out_valid, bufout);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bypass_not_stored: count=%0d out_valid=%b, want 0 0", count, out_valid);
      end
`else
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL nobypass_same_cycle: out_valid=%b want 0", out_valid);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || bufout !== 16'hA5A5 || count !== 3'd1) begin
         errors++;
         $display("FAIL nobypass_next: out_valid=%b bufout=%h count=%0d, want 1 a5a5 1",
                  out_valid, bufout, count);
      end
      tick();
`endif
      out_ready = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL bypass_end_empty: empty=%b want 1", empty);
      end
   endtask

   task automatic test_random();
      logic [31:0] q [$];
      logic        exp_rdy;
      logic        exp_ov;
      logic        byp;
      logic [31:0] exp_d;
      for (int i = 0; i < 200; i++) begin
         in_valid8  = 1'($urandom_range(0, 1));
         out_ready8 = 1'($urandom_range(0, 1));
         bufin8     = $urandom;
         #1;
         exp_rdy = (q.size() < 8);
         byp     = BYP && (q.size() == 0) && in_valid8;
         exp_ov  = (q.size() > 0) || byp;
         exp_d   = (q.size() > 0) ? q[0] : bufin8;
         checks++;
         if (in_ready8 !== exp_rdy || out_valid8 !== exp_ov) begin
            errors++;
            $display("FAIL rand_hs_%0d: in_ready=%b out_valid=%b, want %b %b",
                     i, in_ready8, out_valid8, exp_rdy, exp_ov);
         end
         if (exp_ov) begin
            checks++;
            if (bufout8 !== exp_d) begin
               errors++;
               $display("FAIL rand_data_%0d: bufout=%h want %h", i, bufout8, exp_d);
            end
         end
         if (!(byp && out_ready8)) begin
            if (exp_ov && out_ready8) void'(q.pop_front());
            if (in_valid8 && exp_rdy) q.push_back(bufin8);
         end
         tick();
         checks++;
         if (count8 !== 4'(q.size()) || count8 > 4'd8) begin
            errors++;
            $display("FAIL rand_count_%0d: count=%0d want %0d", i, count8, q.size());
         end
      end
      in_valid8  = 1'b0;
      out_ready8 = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      clr        = 1'b0;
      bufin      = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      clr8       = 1'b0;
      bufin8     = '0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b0;
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_bypass();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/buf_fifo.md
# buf_fifo

Parametrised, registered elastic buffer for the multicycle RISC datapath. It generalises the fixed 16-bit pass-through buffer into a WIDTH-bit, DEPTH-entry FIFO with valid/ready handshakes on both sides, occupancy reporting and a synchronous flush. It sits between datapath stages whose producer and consumer run at different rates, for example the fetch-to-decode or memory-return paths.

## Interface
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, count width (derived localparam, not overridable)

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush; discards all entries
- bufin  in  WIDTH  write data
- in_valid  in  1  producer offers bufin
- in_ready  out  1  buffer accepts; high when not full
- bufout  out  WIDTH  read data at head of queue
- out_valid  out  1  bufout holds a valid entry
- out_ready  in  1  consumer takes bufout
- count  out  CW  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage is a DEPTH×WIDTH register array with wr_ptr and rd_ptr of $clog2(DEPTH) bits each. Both pointers wrap modulo DEPTH naturally.
- push = in_valid && in_ready. It writes bufin at wr_ptr and increments wr_ptr.
- pop = out_valid && out_ready. It increments rd_ptr.
- bufout = mem[rd_ptr], read combinationally from registers (first-word fall-through).
- in_ready = !full. A push is refused when full, even if a pop happens in the same cycle.
- out_valid = !empty. This is overridden when bypass is enabled (see Configuration).
- Occupancy states, derived from count:
  - EMPTY (0): push only → PARTIAL.
  - PARTIAL: push only → count+1, reaching FULL at DEPTH. Pop only → count−1, reaching EMPTY at 0. Push and pop together → count unchanged.
  - FULL (DEPTH): pop → PARTIAL. Push is impossible.
- clr takes priority over push and pop in the same cycle. Pointers and count go to 0. Array contents are not cleared; they are don't-care.
- Data order is strictly FIFO. No entry is lost or duplicated across pointer wrap.
- When out_valid is low, bufout is don't-care; the bench must not check it.

## Timing
- Reset (rst_n low, asynchronous): count=0, wr_ptr=rd_ptr=0, empty=1, full=0, in_ready=1, out_valid=0. bufout is don't-care.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. The first push is accepted on the first rising edge after rst_n deasserts.
- Latency without bypass: data pushed at edge N is visible with out_valid=1 after edge N, so it can be popped in cycle N+1. Minimum latency is 1 cycle.
- Throughput: one push and one pop per cycle when in PARTIAL.
- count, full, empty and in_ready update only on clock edges. out_valid is registered except on the bypass path.
- in_valid and bufin may change freely while in_ready is low. The buffer samples them only on push.

## Configuration
- BUF_BYPASS_EN defined:
  - When empty and in_valid, out_valid=1 and bufout=bufin combinationally.
  - If out_ready is also high, the word passes through with zero latency. It is not stored, and count stays 0.
  - If out_ready is low, the word is stored as a normal push.
  - clr suppresses the bypass.
- BUF_BYPASS_EN undefined:
  - No combinational path from the input side to the output side.
  - Latency is always ≥1 cycle, as described under Timing.

## Test plan
- Reset: drive rst_n=0 mid-stream after 3 pushes → count=0, empty=1, out_valid=0, in_ready=1 immediately, before the next edge.
- Fill/drain, DEPTH=4: push 16'h1111, 16'h2222, 16'h3333, 16'h4444 with out_ready=0 → full=1, in_ready=0, count=4. Attempt a 5th push of 16'hDEAD → refused. Then drain → outputs 1111, 2222, 3333, 4444 in order, then empty=1.
- Simultaneous push and pop at count=2 over 10 cycles with the $random data stream → count stays 2, and the output sequence equals the input sequence delayed by 2 entries. Covers wrap-around.
- Flush: clr=1 together with in_valid=1 at count=3 → next cycle count=0 and empty=1; the pushed word is dropped.
- Random backpressure: 200 cycles of $random in_valid/out_ready with WIDTH=32, DEPTH=8 → scoreboard matches, with no loss or reorder, and count never exceeds 8.
- Bypass, compiled with BUF_BYPASS_EN: empty buffer, in_valid=1, bufin=16'hA5A5, out_ready=1 → bufout=A5A5 and out_valid=1 in the same cycle, count stays 0. Without the macro → out_valid stays 0 that cycle, then goes to 1 with bufout=A5A5 after the edge.
